// File: rtl/mem_arb.sv
// mem_arb: two-to-one memory port arbiter.
//
// The instruction-fetch port (if_*) and the load/store port (ls_*) share a
// single downstream ldst-style master port (m_*). Only one transaction is
// outstanding at a time. The winning request and its owner are registered,
// and the response is routed back to whichever side issued the request.
//
// Optional build macro: MEM_ARB_RR_EN
//   undefined : ldst has priority, and a pending fetch is forced through after
//               LDST_RUN_MAX consecutive ldst grants (anti-starvation counter).
//   defined   : round-robin on ties, using a last-grant register; run_cnt and
//               LDST_RUN_MAX are not used.
//
// Handshake rule for every *_vld/*_rdy pair: a transfer happens on a rising
// clk edge where both vld and rdy are 1. A producer that raises vld holds vld
// and its payload stable until that transfer. rdy may be 1 with vld low.
//
// Debug: dbg_state exposes the FSM state (0=IDLE, 1=REQ, 2=RSP).

module mem_arb #(
  parameter int RV_PC_SIZE   = 32,
  parameter int RV_IR_SIZE   = 32,
  parameter int RV_AW        = 32,
  parameter int RV_XLEN      = 32,
  parameter int LDST_RUN_MAX = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  // fetch request / response
  input  logic                                    if_req_vld,
  output logic                                    if_req_rdy,
  input  logic [RV_PC_SIZE-1:0]                   if_req_pc,
  output logic                                    if_rsp_vld,
  input  logic                                    if_rsp_rdy,
  output logic [RV_IR_SIZE-1:0]                   if_rsp_ir,
  // load/store request / response
  input  logic                                    ls_req_vld,
  output logic                                    ls_req_rdy,
  input  logic [RV_AW+1+RV_XLEN+RV_XLEN/8-1:0]    ls_req_pkt,
  output logic                                    ls_rsp_vld,
  input  logic                                    ls_rsp_rdy,
  output logic [RV_XLEN:0]                        ls_rsp_pkt,
  // shared memory master port
  output logic                                    m_req_vld,
  input  logic                                    m_req_rdy,
  output logic [RV_AW+1+RV_XLEN+RV_XLEN/8-1:0]    m_req_pkt,
  input  logic                                    m_rsp_vld,
  output logic                                    m_rsp_rdy,
  input  logic [RV_XLEN:0]                        m_rsp_pkt,
  // debug
  output logic [1:0]                              dbg_state
);

  localparam int PKT_W = RV_AW + 1 + RV_XLEN + RV_XLEN / 8;
  localparam int RSP_W = RV_XLEN + 1;
  // Scratch width wide enough to zero-extend or truncate the PC onto RV_AW.
  localparam int EXT_W = (RV_PC_SIZE > RV_AW) ? RV_PC_SIZE : RV_AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic OWN_LS = 1'b0;
  localparam logic OWN_IF = 1'b1;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             owner_q;
  logic [PKT_W-1:0] req_q;

  logic             is_idle;
  logic             is_req;
  logic             is_rsp;
  logic             grant_if;
  logic             if_hs;
  logic             ls_hs;
  logic             rsp_hs;
  logic [EXT_W-1:0] pc_ext;
  logic [PKT_W-1:0] fetch_pkt;
  logic             rsp_ok;
  logic [RV_XLEN-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
  logic last_q;
`else
  localparam logic [3:0] RUN_MAX = 4'(LDST_RUN_MAX);
  logic [3:0] run_cnt_q;
`endif

  assign is_idle   = (state_q == IDLE);
  assign is_req    = (state_q == REQ);
  assign is_rsp    = (state_q == RSP);
  assign dbg_state = state_q;

  // Winner selection in IDLE: ldst is the default winner unless fetch alone is
  // asking, or the tie-break hands the grant to fetch.
  always_comb begin
    grant_if = 1'b0;
`ifdef MEM_ARB_RR_EN
    grant_if = if_req_vld && (!ls_req_vld || (last_q == OWN_LS));
`else
    grant_if = if_req_vld && (!ls_req_vld || (run_cnt_q == RUN_MAX));
`endif
  end

  // Only the winner sees rdy, and only while IDLE. Gated by rst_n so every
  // ready output is low while reset is asserted.
  assign if_req_rdy = rst_n && is_idle && grant_if;
  assign ls_req_rdy = rst_n && is_idle && !grant_if;

  assign if_hs = if_req_vld && if_req_rdy;
  assign ls_hs = ls_req_vld && ls_req_rdy;

  // A fetch is presented downstream as a plain read of the PC.
  assign pc_ext    = EXT_W'(if_req_pc);
  assign fetch_pkt = {pc_ext[RV_AW-1:0], 1'b0, {RV_XLEN{1'b0}}, {(RV_XLEN/8){1'b0}}};

  // The request register drives the master port directly, so it stays stable
  // for the whole REQ phase regardless of what the requesters do.
  assign m_req_vld = is_req;
  assign m_req_pkt = req_q;

  // Response path: combinational pass-through to the owner only. Outside RSP
  // any m_rsp_vld is a protocol violation and is left unacknowledged.
  assign rsp_ok   = m_rsp_pkt[0];
  assign rsp_data = m_rsp_pkt[RSP_W-1:1];

  assign if_rsp_vld = is_rsp && (owner_q == OWN_IF) && m_rsp_vld;
  assign ls_rsp_vld = is_rsp && (owner_q == OWN_LS) && m_rsp_vld;
  assign m_rsp_rdy  = is_rsp && ((owner_q == OWN_IF) ? if_rsp_rdy : ls_rsp_rdy);

  // A failed fetch returns an all-zero word, which decodes as illegal.
  assign if_rsp_ir  = rsp_ok ? rsp_data[RV_IR_SIZE-1:0] : {RV_IR_SIZE{1'b0}};
  assign ls_rsp_pkt = m_rsp_pkt;

  assign rsp_hs = m_rsp_vld && m_rsp_rdy;

  // Next-state logic for the IDLE -> REQ -> RSP -> IDLE transaction cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (if_hs || ls_hs) state_d = REQ;
      REQ:  if (m_req_rdy)      state_d = RSP;
      RSP:  if (rsp_hs)         state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted packet and remember who owns the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_LS;
      req_q   <= '0;
    end else if (if_hs) begin
      owner_q <= OWN_IF;
      req_q   <= fetch_pkt;
    end else if (ls_hs) begin
      owner_q <= OWN_LS;
      req_q   <= ls_req_pkt;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-grant register; starts at IF so ldst wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_IF;
    end else if (if_hs) begin
      last_q <= OWN_IF;
    end else if (ls_hs) begin
      last_q <= OWN_LS;
    end
  end
`else
  // Count ldst grants taken while a fetch is waiting; any fetch grant, or an
  // ldst grant with no fetch waiting, clears the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= 4'd0;
    end else if (if_hs) begin
      run_cnt_q <= 4'd0;
    end else if (ls_hs) begin
      if (!if_req_vld) begin
        run_cnt_q <= 4'd0;
      end else if (run_cnt_q != RUN_MAX) begin
        run_cnt_q <= run_cnt_q + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with default parameters
// (32-bit PC/IR/address/data, LDST_RUN_MAX=4). A per-cycle vector table covers
// the basic fetch/store/error/stray-response cases; hand-written sequences
// cover grant order, backpressure and reset in the middle of a transaction.

module tb_mem_arb;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req_vld, if_req_rdy;
  logic [31:0] if_req_pc;
  logic        if_rsp_vld, if_rsp_rdy;
  logic [31:0] if_rsp_ir;
  logic        ls_req_vld, ls_req_rdy;
  logic [68:0] ls_req_pkt;
  logic        ls_rsp_vld, ls_rsp_rdy;
  logic [32:0] ls_rsp_pkt;
  logic        m_req_vld, m_req_rdy;
  logic [68:0] m_req_pkt;
  logic        m_rsp_vld, m_rsp_rdy;
  logic [32:0] m_rsp_pkt;
  logic [1:0]  dbg_state;

  mem_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_vld (if_req_vld),
    .if_req_rdy (if_req_rdy),
    .if_req_pc  (if_req_pc),
    .if_rsp_vld (if_rsp_vld),
    .if_rsp_rdy (if_rsp_rdy),
    .if_rsp_ir  (if_rsp_ir),
    .ls_req_vld (ls_req_vld),
    .ls_req_rdy (ls_req_rdy),
    .ls_req_pkt (ls_req_pkt),
    .ls_rsp_vld (ls_rsp_vld),
    .ls_rsp_rdy (ls_rsp_rdy),
    .ls_rsp_pkt (ls_rsp_pkt),
    .m_req_vld  (m_req_vld),
    .m_req_rdy  (m_req_rdy),
    .m_req_pkt  (m_req_pkt),
    .m_rsp_vld  (m_rsp_vld),
    .m_rsp_rdy  (m_rsp_rdy),
    .m_rsp_pkt  (m_rsp_pkt),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [68:0] lp(input logic [31:0] a, input logic s,
                                     input logic [31:0] d, input logic [3:0] b);
    return {a, s, d, b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    if_req_vld = 1'b0; if_req_pc = '0; if_rsp_rdy = 1'b0;
    ls_req_vld = 1'b0; ls_req_pkt = '0; ls_rsp_rdy = 1'b0;
    m_req_rdy  = 1'b0; m_rsp_vld = 1'b0; m_rsp_pkt = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ifv;  logic [31:0] pc;
    logic        lsv;  logic [68:0] lspkt;
    logic        mrr;  logic        mrv;  logic [32:0] mrsp;
    logic        ifrr; logic        lsrr;
    logic        e_ifr; logic e_lsr; logic e_mrv; logic [68:0] e_mpkt;
    logic        e_ifv; logic [31:0] e_ir;
    logic        e_lsv; logic [32:0] e_lspkt;
    logic        e_mrr; logic [1:0]  e_st;
  } vec_t;

  function automatic vec_t mk(
    input logic ifv, input logic [31:0] pc, input logic lsv, input logic [68:0] lspkt,
    input logic mrr, input logic mrv, input logic [32:0] mrsp, input logic ifrr, input logic lsrr,
    input logic e_ifr, input logic e_lsr, input logic e_mrv, input logic [68:0] e_mpkt,
    input logic e_ifv, input logic [31:0] e_ir, input logic e_lsv, input logic [32:0] e_lspkt,
    input logic e_mrr, input logic [1:0] e_st);
    vec_t v;
    v.ifv = ifv; v.pc = pc; v.lsv = lsv; v.lspkt = lspkt;
    v.mrr = mrr; v.mrv = mrv; v.mrsp = mrsp; v.ifrr = ifrr; v.lsrr = lsrr;
    v.e_ifr = e_ifr; v.e_lsr = e_lsr; v.e_mrv = e_mrv; v.e_mpkt = e_mpkt;
    v.e_ifv = e_ifv; v.e_ir = e_ir; v.e_lsv = e_lsv; v.e_lspkt = e_lspkt;
    v.e_mrr = e_mrr; v.e_st = e_st;
    return v;
  endfunction

  vec_t vt[17];

  task automatic apply_row(input int i, input vec_t v);
    if_req_vld = v.ifv; if_req_pc = v.pc;
    ls_req_vld = v.lsv; ls_req_pkt = v.lspkt;
    m_req_rdy  = v.mrr; m_rsp_vld = v.mrv; m_rsp_pkt = v.mrsp;
    if_rsp_rdy = v.ifrr; ls_rsp_rdy = v.lsrr;
    @(negedge clk);
    chk($sformatf("row%0d if_req_rdy", i), if_req_rdy, v.e_ifr);
    chk($sformatf("row%0d ls_req_rdy", i), ls_req_rdy, v.e_lsr);
    chk($sformatf("row%0d m_req_vld", i),  m_req_vld,  v.e_mrv);
    chk($sformatf("row%0d m_req_pkt", i),  m_req_pkt,  v.e_mpkt);
    chk($sformatf("row%0d if_rsp_vld", i), if_rsp_vld, v.e_ifv);
    chk($sformatf("row%0d ls_rsp_vld", i), ls_rsp_vld, v.e_lsv);
    chk($sformatf("row%0d m_rsp_rdy", i),  m_rsp_rdy,  v.e_mrr);
    chk($sformatf("row%0d state", i),      dbg_state,  v.e_st);
    if (v.e_ifv) chk($sformatf("row%0d if_rsp_ir", i), if_rsp_ir, v.e_ir);
    if (v.e_lsv) chk($sformatf("row%0d ls_rsp_pkt", i), ls_rsp_pkt, v.e_lspkt);
    step();
  endtask

  // ---------------- test ----------------
  logic [68:0] pk_f1, pk_f2, pk_st, pk_ld;
  logic        g;
  int          got;

  initial begin
    pk_f1 = lp(32'h100, 1'b0, 32'h0, 4'h0);
    pk_f2 = lp(32'h104, 1'b0, 32'h0, 4'h0);
    pk_st = lp(32'h2000, 1'b1, 32'hDEADBEEF, 4'hF);
    pk_ld = lp(32'h3000, 1'b0, 32'h0, 4'hF);

    //             ifv pc       lsv lspkt  mrr mrv mrsp                     ifrr lsrr  ifr lsr mrv mpkt   ifv ir            lsv lspkt                    mrr st
    vt[0]  = mk(0, 32'h0,   0, '0,    0, 0, '0,                      1, 1,  0, 1, 0, '0,    0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[1]  = mk(1, 32'h100, 0, '0,    0, 0, '0,                      1, 1,  1, 0, 0, '0,    0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[2]  = mk(0, 32'h0,   0, '0,    1, 0, '0,                      1, 1,  0, 0, 1, pk_f1, 0, 32'h0,        0, '0,                      0, S_REQ);
    vt[3]  = mk(0, 32'h0,   0, '0,    0, 1, {32'h00500093, 1'b1},    1, 1,  0, 0, 0, pk_f1, 1, 32'h00500093, 0, '0,                      1, S_RSP);
    vt[4]  = mk(0, 32'h0,   0, '0,    0, 0, '0,                      1, 1,  0, 1, 0, pk_f1, 0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[5]  = mk(0, 32'h0,   1, pk_st, 0, 0, '0,                      1, 1,  0, 1, 0, pk_f1, 0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[6]  = mk(0, 32'h0,   0, '0,    0, 0, '0,                      1, 1,  0, 0, 1, pk_st, 0, 32'h0,        0, '0,                      0, S_REQ);
    vt[7]  = mk(0, 32'h0,   0, '0,    1, 0, '0,                      1, 1,  0, 0, 1, pk_st, 0, 32'h0,        0, '0,                      0, S_REQ);
    vt[8]  = mk(0, 32'h0,   0, '0,    0, 1, {32'h0, 1'b1},           1, 1,  0, 0, 0, pk_st, 0, 32'h0,        1, {32'h0, 1'b1},           1, S_RSP);
    vt[9]  = mk(1, 32'h104, 0, '0,    0, 0, '0,                      1, 1,  1, 0, 0, pk_st, 0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[10] = mk(0, 32'h0,   0, '0,    1, 1, {32'hCAFE, 1'b1},        1, 1,  0, 0, 1, pk_f2, 0, 32'h0,        0, '0,                      0, S_REQ);
    vt[11] = mk(0, 32'h0,   0, '0,    0, 1, {32'h12345678, 1'b0},    1, 1,  0, 0, 0, pk_f2, 1, 32'h0,        0, '0,                      1, S_RSP);
    vt[12] = mk(0, 32'h0,   0, '0,    0, 1, {32'h5555, 1'b1},        1, 1,  0, 1, 0, pk_f2, 0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[13] = mk(1, 32'h108, 1, pk_ld, 0, 0, '0,                      1, 1,  0, 1, 0, pk_f2, 0, 32'h0,        0, '0,                      0, S_IDLE);
    vt[14] = mk(1, 32'h108, 0, '0,    1, 0, '0,                      1, 1,  0, 0, 1, pk_ld, 0, 32'h0,        0, '0,                      0, S_REQ);
    vt[15] = mk(1, 32'h108, 0, '0,    0, 1, {32'hA5A5A5A5, 1'b1},    1, 1,  0, 0, 0, pk_ld, 0, 32'h0,        1, {32'hA5A5A5A5, 1'b1},    1, S_RSP);
    vt[16] = mk(1, 32'h108, 0, '0,    0, 0, '0,                      1, 1,  1, 0, 0, pk_ld, 0, 32'h0,        0, '0,                      0, S_IDLE);

    // Reset state, sampled while rst_n is still low.
    clr_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset state",      dbg_state,  S_IDLE);
    chk("reset if_req_rdy", if_req_rdy, 1'b0);
    chk("reset ls_req_rdy", ls_req_rdy, 1'b0);
    chk("reset m_req_vld",  m_req_vld,  1'b0);
    chk("reset m_req_pkt",  m_req_pkt,  69'h0);
    chk("reset rsp_vld",    {if_rsp_vld, ls_rsp_vld}, 2'b00);
    chk("reset m_rsp_rdy",  m_rsp_rdy,  1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) apply_row(i, vt[i]);

    // Grant order with both requesters held valid continuously.
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    if_req_vld = 1'b1; if_req_pc = 32'h400;
    ls_req_vld = 1'b1; ls_req_pkt = pk_ld;
    m_req_rdy = 1'b1; m_rsp_vld = 1'b1; m_rsp_pkt = {32'h1, 1'b1};
    if_rsp_rdy = 1'b1; ls_rsp_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      if (if_req_rdy || ls_req_rdy) begin
        g = if_req_rdy;
        chk($sformatf("grant%0d is_fetch", got), g, exp_q.pop_front());
        got++;
      end
      step();
    end
    if (got < 6) begin
      checks++;
      errors++;
      $display("FAIL grant order timeout: got %0d grants expected 6", got);
    end

    // Downstream request backpressure, then fetch response backpressure.
    do_reset();
    ls_req_vld = 1'b1; ls_req_pkt = pk_st;
    @(negedge clk);
    chk("bp store grant", ls_req_rdy, 1'b1);
    step();
    ls_req_pkt = pk_ld;
    if_req_vld = 1'b1; if_req_pc = 32'h500;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d m_req_vld", c), m_req_vld, 1'b1);
      chk($sformatf("bp%0d m_req_pkt", c), m_req_pkt, pk_st);
      chk($sformatf("bp%0d req_rdy", c), {if_req_rdy, ls_req_rdy}, 2'b00);
      chk($sformatf("bp%0d state", c), dbg_state, S_REQ);
      step();
    end
    m_req_rdy = 1'b1;
    step();
    ls_req_vld = 1'b0; m_req_rdy = 1'b0;
    m_rsp_vld = 1'b1; m_rsp_pkt = {32'h0, 1'b1}; ls_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp store rsp ls_rsp_vld", ls_rsp_vld, 1'b1);
    chk("bp store rsp if_rsp_vld", if_rsp_vld, 1'b0);
    chk("bp store rsp m_rsp_rdy", m_rsp_rdy, 1'b1);
    step();
    m_rsp_vld = 1'b0;
    @(negedge clk);
    chk("bp fetch grant", if_req_rdy, 1'b1);
    step();
    if_req_vld = 1'b0; m_req_rdy = 1'b1;
    @(negedge clk);
    chk("bp fetch m_req_pkt", m_req_pkt, lp(32'h500, 1'b0, 32'h0, 4'h0));
    step();
    m_req_rdy = 1'b0; m_rsp_vld = 1'b1; m_rsp_pkt = {32'h00A00113, 1'b1}; if_rsp_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rspbp%0d m_rsp_rdy", c), m_rsp_rdy, 1'b0);
      chk($sformatf("rspbp%0d state", c), dbg_state, S_RSP);
      chk($sformatf("rspbp%0d rsp_vld", c), {if_rsp_vld, ls_rsp_vld}, 2'b10);
      step();
    end
    if_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("rspbp release m_rsp_rdy", m_rsp_rdy, 1'b1);
    chk("rspbp release if_rsp_ir", if_rsp_ir, 32'h00A00113);
    step();
    m_rsp_vld = 1'b0;
    @(negedge clk);
    chk("rspbp back to idle", dbg_state, S_IDLE);
    step();

    // Reset while a request is waiting downstream, then a clean fetch.
    do_reset();
    if_req_vld = 1'b1; if_req_pc = 32'h200;
    @(negedge clk);
    chk("rst fetch grant", if_req_rdy, 1'b1);
    step();
    if_req_vld = 1'b0;
    @(negedge clk);
    chk("rst pre m_req_vld", m_req_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst async m_req_vld", m_req_vld, 1'b0);
    chk("rst async state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst after m_req_vld", m_req_vld, 1'b0);
    chk("rst after state", dbg_state, S_IDLE);
    step();
    if_req_vld = 1'b1; if_req_pc = 32'h300;
    @(negedge clk);
    chk("rst new fetch grant", if_req_rdy, 1'b1);
    step();
    if_req_vld = 1'b0; m_req_rdy = 1'b1;
    @(negedge clk);
    chk("rst new m_req_pkt", m_req_pkt, lp(32'h300, 1'b0, 32'h0, 4'h0));
    step();
    m_req_rdy = 1'b0; m_rsp_vld = 1'b1; m_rsp_pkt = {32'h00000013, 1'b1}; if_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("rst new if_rsp_vld", if_rsp_vld, 1'b1);
    chk("rst new if_rsp_ir", if_rsp_ir, 32'h00000013);
    step();
    m_rsp_vld = 1'b0;
    @(negedge clk);
    chk("rst new idle", dbg_state, S_IDLE);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
